// File: rtl/pc_sequencer.sv
// Multi-cycle instruction sequencer for the MIPS datapath: owns the pc, steps
// FETCH/DECODE/EXEC/MEM/WB and gates control-unit strobes to one commit per instruction.
module pc_sequencer #(
    parameter int                  PC_WIDTH    = 32,
    parameter logic [PC_WIDTH-1:0] PC_RESET    = '0,
    parameter logic [PC_WIDTH-1:0] PC_STEP     = 1,
    parameter logic [PC_WIDTH-1:0] PC_LAST     = 31,
    parameter logic [5:0]          HALT_OPCODE = 6'b111111
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                step_mode,
    input  logic [5:0]          opcode,
    input  logic                reg_write,
    input  logic                mem_read,
    input  logic                mem_write,
    input  logic                mem_ready,
    output logic [PC_WIDTH-1:0] pc,
    output logic [2:0]          state,
    output logic                reg_we_gate,
    output logic                mem_re_gate,
    output logic                mem_we_gate,
    output logic                busy,
    output logic                halted,
    output logic [31:0]         instr_count
);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_FETCH  = 3'd1;
    localparam logic [2:0] ST_DECODE = 3'd2;
    localparam logic [2:0] ST_EXEC   = 3'd3;
    localparam logic [2:0] ST_MEM    = 3'd4;
    localparam logic [2:0] ST_WB     = 3'd5;
    localparam logic [2:0] ST_HALT   = 3'd6;

    logic [2:0]          state_q, state_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic [31:0]         count_q, count_d;
    logic                at_last;

    assign at_last = (pc_q == PC_LAST);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        count_d = count_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (opcode == HALT_OPCODE) begin
                    state_d = ST_HALT;
                end else begin
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                if (mem_read || mem_write) begin
                    state_d = ST_MEM;
                end else begin
                    state_d = ST_WB;
                end
            end
            ST_MEM: begin
                if (mem_ready) begin
                    state_d = ST_WB;
                end
            end
            ST_WB: begin
                count_d = count_q + 32'd1;
                // End-of-program check uses the pre-increment pc.
                if (at_last) begin
                    pc_d    = PC_RESET;
                    state_d = ST_HALT;
                end else begin
                    pc_d    = pc_q + PC_STEP;
                    state_d = step_mode ? ST_IDLE : ST_FETCH;
                end
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            pc_q    <= PC_RESET;
            count_q <= 32'd0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            count_q <= count_d;
        end
    end

    // Strobes pass through only in their commit state; writes need mem_ready so
    // a waited store produces a single pulse.
    always_comb begin
        reg_we_gate = (state_q == ST_WB)  && reg_write;
        mem_re_gate = (state_q == ST_MEM) && mem_read;
        mem_we_gate = (state_q == ST_MEM) && mem_write && mem_ready;
        busy        = (state_q != ST_IDLE) && (state_q != ST_HALT);
        halted      = (state_q == ST_HALT);
    end

    assign pc          = pc_q;
    assign state       = state_q;
    assign instr_count = count_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: per-cycle expected outputs are queued as the
// stimulus is driven and compared on the falling edge.
module tb_pc_sequencer;

    localparam logic [2:0] IDLE = 3'd0, FETCH = 3'd1, DECODE = 3'd2, EXEC = 3'd3,
                           MEM = 3'd4, WB = 3'd5, HALT = 3'd6;

    logic        clk = 1'b0;
    logic        rst, start, step_mode, reg_write, mem_read, mem_write, mem_ready;
    logic [5:0]  opcode;

    logic [31:0] pc_a, cnt_a, pc_b, cnt_b;
    logic [2:0]  st_a, st_b;
    logic        rw_a, re_a, mw_a, busy_a, halt_a;
    logic        rw_b, re_b, mw_b, busy_b, halt_b;

    logic [72:0] exp_q[$];
    string       tag_q[$];
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    pc_sequencer dut_a (
        .clk(clk), .rst(rst), .start(start), .step_mode(step_mode), .opcode(opcode),
        .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write),
        .mem_ready(mem_ready), .pc(pc_a), .state(st_a), .reg_we_gate(rw_a),
        .mem_re_gate(re_a), .mem_we_gate(mw_a), .busy(busy_a), .halted(halt_a),
        .instr_count(cnt_a)
    );

    pc_sequencer #(.PC_LAST(32'd3)) dut_b (
        .clk(clk), .rst(rst), .start(start), .step_mode(step_mode), .opcode(opcode),
        .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write),
        .mem_ready(mem_ready), .pc(pc_b), .state(st_b), .reg_we_gate(rw_b),
        .mem_re_gate(re_b), .mem_we_gate(mw_b), .busy(busy_b), .halted(halt_b),
        .instr_count(cnt_b)
    );

    // Scoreboard: one queued expectation is consumed per falling edge.
    always @(negedge clk) begin
        logic [72:0] e;
        logic [71:0] obs;
        string       t;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            obs = e[72] ? {st_b, pc_b, cnt_b, rw_b, re_b, mw_b, busy_b, halt_b}
                        : {st_a, pc_a, cnt_a, rw_a, re_a, mw_a, busy_a, halt_a};
            checks++;
            assert (obs === e[71:0]) else begin
                errors++;
                $error("FAIL %s: observed st=%0d pc=%0d cnt=%0d rw/re/mw/busy/halt=%b expected st=%0d pc=%0d cnt=%0d rw/re/mw/busy/halt=%b",
                       t, obs[71:69], obs[68:37], obs[36:5], obs[4:0],
                       e[71:69], e[68:37], e[36:5], e[4:0]);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Queue expected outputs for the current cycle, then advance one cycle.
    task automatic cyc(input string tag, input logic sel, input logic [2:0] st,
                       input logic [31:0] p, input logic [31:0] c,
                       input logic rw, input logic re, input logic mw);
        logic busy_e, halt_e;
        busy_e = (st != IDLE) && (st != HALT);
        halt_e = (st == HALT);
        exp_q.push_back({sel, st, p, c, rw, re, mw, busy_e, halt_e});
        tag_q.push_back(tag);
        tick();
    endtask

    task automatic plain_instr(input logic sel, input logic [31:0] p, input logic [31:0] c,
                               input logic rw);
        reg_write = rw;
        cyc("plain_fetch", sel, FETCH, p, c, 1'b0, 1'b0, 1'b0);
        cyc("plain_decode", sel, DECODE, p, c, 1'b0, 1'b0, 1'b0);
        cyc("plain_exec", sel, EXEC, p, c, 1'b0, 1'b0, 1'b0);
        cyc("plain_wb", sel, WB, p, c, rw, 1'b0, 1'b0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; step_mode = 1'b0; opcode = 6'd0;
        reg_write = 1'b0; mem_read = 1'b0; mem_write = 1'b0; mem_ready = 1'b0;

        // Reset
        tick();
        tick();
        cyc("reset_a", 1'b0, IDLE, 0, 0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0; reg_write = 1'b1; mem_read = 1'b1; mem_write = 1'b1; mem_ready = 1'b1;
        cyc("idle_gates_b", 1'b1, IDLE, 0, 0, 1'b0, 1'b0, 1'b0);

        // Plain register instruction
        start = 1'b1; opcode = 6'd0; reg_write = 1'b1;
        mem_read = 1'b0; mem_write = 1'b0; mem_ready = 1'b0;
        cyc("idle_start", 1'b0, IDLE, 0, 0, 1'b0, 1'b0, 1'b0);
        cyc("fetch0_start_busy", 1'b0, FETCH, 0, 0, 1'b0, 1'b0, 1'b0);
        start = 1'b0;
        cyc("decode0", 1'b0, DECODE, 0, 0, 1'b0, 1'b0, 1'b0);
        cyc("exec0", 1'b0, EXEC, 0, 0, 1'b0, 1'b0, 1'b0);
        cyc("wb0", 1'b0, WB, 0, 0, 1'b1, 1'b0, 1'b0);

        // Load with three wait cycles
        mem_read = 1'b1; reg_write = 1'b1;
        cyc("lw_fetch", 1'b0, FETCH, 1, 1, 1'b0, 1'b0, 1'b0);
        cyc("lw_decode", 1'b0, DECODE, 1, 1, 1'b0, 1'b0, 1'b0);
        cyc("lw_exec", 1'b0, EXEC, 1, 1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cyc("lw_mem_wait", 1'b0, MEM, 1, 1, 1'b0, 1'b1, 1'b0);
        end
        mem_ready = 1'b1;
        cyc("lw_mem_ready", 1'b0, MEM, 1, 1, 1'b0, 1'b1, 1'b0);
        mem_ready = 1'b0;
        cyc("lw_wb", 1'b0, WB, 1, 1, 1'b1, 1'b0, 1'b0);

        // Store with immediate ready
        mem_read = 1'b0; mem_write = 1'b1; reg_write = 1'b0; mem_ready = 1'b1;
        cyc("sw_fetch", 1'b0, FETCH, 2, 2, 1'b0, 1'b0, 1'b0);
        cyc("sw_decode", 1'b0, DECODE, 2, 2, 1'b0, 1'b0, 1'b0);
        cyc("sw_exec", 1'b0, EXEC, 2, 2, 1'b0, 1'b0, 1'b0);
        cyc("sw_mem", 1'b0, MEM, 2, 2, 1'b0, 1'b0, 1'b1);
        cyc("sw_wb", 1'b0, WB, 2, 2, 1'b0, 1'b0, 1'b0);

        mem_write = 1'b0; mem_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            plain_instr(1'b0, 3 + k, 3 + k, 1'($urandom_range(0, 1)));
        end

        // Halt opcode at pc=5, then sticky
        opcode = 6'h3f;
        cyc("halt_fetch", 1'b0, FETCH, 5, 5, 1'b0, 1'b0, 1'b0);
        opcode = 6'd0; start = 1'b1; reg_write = 1'b1; mem_read = 1'b1;
        mem_write = 1'b1; mem_ready = 1'b1;
        cyc("halt_entered", 1'b0, HALT, 5, 5, 1'b0, 1'b0, 1'b0);
        start = 1'b0;
        cyc("halt_sticky", 1'b0, HALT, 5, 5, 1'b0, 1'b0, 1'b0);
        start = 1'b1; step_mode = 1'b1;
        cyc("halt_ignore_start", 1'b0, HALT, 5, 5, 1'b0, 1'b0, 1'b0);

        // Short program (PC_LAST=3) in step mode
        rst = 1'b1; start = 1'b0; reg_write = 1'b0; mem_read = 1'b0;
        mem_write = 1'b0; mem_ready = 1'b0;
        tick();
        rst = 1'b0; start = 1'b1; step_mode = 1'b1;
        cyc("b_reset", 1'b1, IDLE, 0, 0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            start = 1'b0;
            plain_instr(1'b1, i, i, 1'b1);
            if (i < 3) begin
                cyc("b_step_idle", 1'b1, IDLE, i + 1, i + 1, 1'b0, 1'b0, 1'b0);
                start = 1'b1;
                cyc("b_step_resume", 1'b1, IDLE, i + 1, i + 1, 1'b0, 1'b0, 1'b0);
            end
        end
        start = 1'b1;
        cyc("b_end_wrap", 1'b1, HALT, 0, 4, 1'b0, 1'b0, 1'b0);
        cyc("b_end_sticky", 1'b1, HALT, 0, 4, 1'b0, 1'b0, 1'b0);

        // Reset during a memory wait
        rst = 1'b1; start = 1'b0;
        cyc("b_rst_from_halt", 1'b1, HALT, 0, 4, 1'b0, 1'b0, 1'b0);
        rst = 1'b0; start = 1'b1; step_mode = 1'b0;
        cyc("b_restart", 1'b1, IDLE, 0, 0, 1'b0, 1'b0, 1'b0);
        start = 1'b0;
        plain_instr(1'b1, 0, 0, 1'b1);
        mem_read = 1'b1; mem_ready = 1'b0;
        cyc("b_lw_fetch", 1'b1, FETCH, 1, 1, 1'b0, 1'b0, 1'b0);
        cyc("b_lw_decode", 1'b1, DECODE, 1, 1, 1'b0, 1'b0, 1'b0);
        cyc("b_lw_exec", 1'b1, EXEC, 1, 1, 1'b0, 1'b0, 1'b0);
        cyc("b_lw_wait", 1'b1, MEM, 1, 1, 1'b0, 1'b1, 1'b0);
        rst = 1'b1;
        cyc("b_rst_in_mem", 1'b1, MEM, 1, 1, 1'b0, 1'b1, 1'b0);
        rst = 1'b0; mem_ready = 1'b1; mem_write = 1'b1;
        cyc("b_after_rst", 1'b1, IDLE, 0, 0, 1'b0, 1'b0, 1'b0);

        @(negedge clk);
        #1;
        checks++;
        assert (exp_q.size() == 0) else begin
            errors++;
            $error("FAIL queue_drain: observed %0d pending expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
